io_input_port: RTL and testbench

IO_INPUT_PORT -- requirements
Module: io_input_port

---
 rtl/io_map_pkg.sv | 12 +
 rtl/io_in_debounce.sv | 71 +++++++
 rtl/io_input_port.sv | 73 +++++++
 tb/tb_io_input_port.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared CPU I/O address map: I/O select bit and word indices used by the input and output port blocks.
package io_map_pkg;

    localparam int IO_SEL_BIT = 7;

    typedef logic [4:0] io_idx_t;

    localparam io_idx_t IDX_PORT0  = 5'd0;
    localparam io_idx_t IDX_PORT1  = 5'd1;
    localparam io_idx_t IDX_STATUS = 5'd2;

endpackage

// File: rtl/io_in_debounce.sv
// One input port: two-flop synchronizer, optional stability counter (IO_INPUT_DEBOUNCE_EN),
// debounced register and a one-cycle pulse flagging the edge at which deb takes a new value.
module io_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] din,
    output logic [31:0] deb,
    output logic        chg_set
);

    logic [31:0] s1;
    logic [31:0] s2;

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [31:0] s2_d;
    logic [7:0]  cnt;
    logic        differs;
    logic        stable;

    always_comb begin
        differs = (s2 != deb);
        stable  = (s2 == s2_d);
        chg_set = differs && stable && (cnt == CNT_LAST);
    end

    // Any wobble of s2, or s2 falling back to deb, restarts the stability count.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= '0;
            deb  <= '0;
            cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so s1->s2->s2_d shift as a true pipeline in one edge.
            s1   <= din;
            s2   <= s1;
            s2_d <= s2;
            if (!differs || !stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    always_comb chg_set = (s2 != deb);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
        end else begin
            s1  <= din;
            s2  <= s1;
            deb <= s2;
        end
    end
`endif

endmodule

// File: rtl/io_input_port.sv
// CPU-readable input port block: two debounced ports plus sticky change flags with read-to-clear.
// Debounce counters are built only when IO_INPUT_DEBOUNCE_EN is defined.
module io_input_port
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] io_read_data
);

    logic [31:0] deb0;
    logic [31:0] deb1;
    logic        set0;
    logic        set1;
    logic [1:0]  chg;
    logic        io_sel;
    io_idx_t     idx;
    logic        status_clr;
    logic        unused_addr_bits;

    io_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port0 (
        .clock   (clock),
        .resetn  (resetn),
        .din     (in_port0),
        .deb     (deb0),
        .chg_set (set0)
    );

    io_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port1 (
        .clock   (clock),
        .resetn  (resetn),
        .din     (in_port1),
        .deb     (deb1),
        .chg_set (set1)
    );

    assign io_sel           = addr[IO_SEL_BIT];
    assign idx              = addr[6:2];
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};
    assign status_clr       = re && io_sel && (idx == IDX_STATUS);

    // A change arriving on the same edge as a status read wins, so no event is lost.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            chg <= '0;
        end else begin
            if (set0)            chg[0] <= 1'b1;
            else if (status_clr) chg[0] <= 1'b0;
            if (set1)            chg[1] <= 1'b1;
            else if (status_clr) chg[1] <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        io_read_data = '0;
        if (io_sel) begin
            case (idx)
                IDX_PORT0:  io_read_data = deb0;
                IDX_PORT1:  io_read_data = deb1;
                IDX_STATUS: io_read_data = {30'b0, chg[1], chg[0]};
                default:    io_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_port.sv
// Self-checking bench for io_input_port with DEBOUNCE_CYCLES=4; works with or without IO_INPUT_DEBOUNCE_EN.
module tb_io_input_port;

    localparam int N = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = '0;
    logic        re = 1'b0;
    logic [31:0] in_port0 = '0;
    logic [31:0] in_port1 = '0;
    logic [31:0] io_read_data;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    io_input_port #(.DEBOUNCE_CYCLES(N)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .addr         (addr),
        .re           (re),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .io_read_data (io_read_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a read, queue its expected data, then pop and compare the combinational result.
    task automatic expect_read(input string tag, input logic [31:0] a, input logic r, input logic [31:0] exp);
        sb_item_t it;
        addr = a;
        re   = r;
        sb_q.push_back('{tag: tag, val: exp});
        #1;
        it = sb_q.pop_front();
        check(it.tag, io_read_data, it.val);
    endtask

    initial begin
        // Reset with port0 driven high: everything must decode to 0.
        resetn   = 1'b0;
        in_port0 = 32'hFFFF_FFFF;
        repeat (2) tick();
        expect_read("rst_p0", 32'h80, 1'b0, 32'h0);
        expect_read("rst_p1", 32'h84, 1'b0, 32'h0);
        expect_read("rst_st", 32'h88, 1'b0, 32'h0);

        in_port0 = 32'h0;
        resetn   = 1'b1;
        repeat (20) tick();
        expect_read("idle_st", 32'h88, 1'b0, 32'h0);

        // Exact latency from s1 capture to deb visibility.
        in_port0 = 32'h0000_00A5;
        tick();
        repeat (LAT - 1) tick();
        expect_read("lat_early", 32'h80, 1'b0, 32'h0);
        tick();
        expect_read("lat_p0", 32'h80, 1'b0, 32'h0000_00A5);
        expect_read("lat_st", 32'h88, 1'b0, 32'h1);

        // Status read without re keeps chg; with re clears it.
        tick();
        expect_read("noclr_st", 32'h88, 1'b0, 32'h1);
        expect_read("clr_rd", 32'h88, 1'b1, 32'h1);
        tick();
        expect_read("clr_after", 32'h88, 1'b0, 32'h0);

`ifdef IO_INPUT_DEBOUNCE_EN
        // A 3-cycle pulse is shorter than the debounce window and must vanish.
        in_port1 = 32'h1;
        repeat (3) tick();
        in_port1 = 32'h0;
        repeat (12) tick();
        expect_read("glitch_p1", 32'h84, 1'b0, 32'h0);
        expect_read("glitch_st", 32'h88, 1'b0, 32'h0);
`else
        in_port0 = 32'h0000_1234;
        tick();
        tick();
        expect_read("nd_early", 32'h80, 1'b0, 32'h0000_00A5);
        tick();
        expect_read("nd_p0", 32'h80, 1'b0, 32'h0000_1234);
        expect_read("nd_clr", 32'h88, 1'b1, 32'h1);
        tick();
`endif
        expect_read("unmapped_8c", 32'h8C, 1'b0, 32'h0);
        expect_read("non_io", 32'h04, 1'b0, 32'h0);

        // deb0 update lands on the same edge as a read-to-clear: set wins.
        in_port0 = 32'h0000_005A;
        tick();
        repeat (LAT - 1) tick();
        expect_read("race_pre", 32'h88, 1'b1, 32'h0);
        tick();
        expect_read("race_st", 32'h88, 1'b0, 32'h1);
        expect_read("race_p0", 32'h80, 1'b0, 32'h0000_005A);
        expect_read("race_clr", 32'h88, 1'b1, 32'h1);
        tick();

        // Both ports change together.
        in_port0 = 32'h0F0F_0F0F;
        in_port1 = 32'hCAFE_F00D;
        tick();
        repeat (LAT) tick();
        expect_read("both_p0", 32'h80, 1'b0, 32'h0F0F_0F0F);
        expect_read("both_p1", 32'h84, 1'b0, 32'hCAFE_F00D);
        expect_read("both_st", 32'h88, 1'b0, 32'h3);

        // Reset in the middle of a count restarts the full latency.
        in_port1 = 32'h0000_0077;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        expect_read("mid_rst_p0", 32'h80, 1'b0, 32'h0);
        expect_read("mid_rst_p1", 32'h84, 1'b0, 32'h0);
        tick();
        repeat (LAT - 1) tick();
        expect_read("restart_early", 32'h84, 1'b0, 32'h0);
        tick();
        expect_read("restart_p1", 32'h84, 1'b0, 32'h0000_0077);
        expect_read("restart_p0", 32'h80, 1'b0, 32'h0F0F_0F0F);
        expect_read("restart_st", 32'h88, 1'b0, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
